// File: rtl/ultrasonic_ranger_mc.sv
// Multi-channel ultrasonic ranger. Channels are triggered round-robin, one per slot.
// Each echo width becomes a sample that feeds a per-channel moving average and a bar indicator.
module ultrasonic_ranger_mc #(
   parameter int NCH         = 2,
   parameter int TRIG_CYC    = 22,
   parameter int SLOT_CYC    = 131072,
   parameter int TIMEOUT_CYC = 65535,
   parameter int SCALE_SH    = 8,
   parameter int SMP_W       = 8,
   parameter int AVG_LOG2    = 2
) (
   input  logic                 osc_clk,
   input  logic                 stdby_in,
   input  logic [NCH-1:0]       echo,
   input  logic [2:0]           led_sel,
   output logic [NCH-1:0]       trig,
   output logic                 range_valid,
   output logic [2:0]           range_ch,
   output logic [SMP_W-1:0]     range_avg,
   output logic                 range_timeout,
   output logic [NCH*SMP_W-1:0] dist_flat,
   output logic [SMP_W-1:0]     bar
);

   localparam int SC_W  = $clog2(SLOT_CYC + 1);
   localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int SUM_W = SMP_W + AVG_LOG2;
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [SC_W-1:0]  SLOT_LAST = SC_W'(SLOT_CYC - 1);
   localparam logic [SC_W-1:0]  TRIG_LAST = SC_W'(TRIG_CYC - 1);
   localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT_CYC);
   localparam logic [SMP_W-1:0] SAT       = {SMP_W{1'b1}};
   localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NCH - 1);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_TRIG = 2'd0,
      S_WAIT = 2'd1,
      S_MEAS = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   logic [NCH-1:0]   sync1_q, sync2_q, prev_q;
   logic [SC_W-1:0]  slot_q, slot_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   state_t           state_q, state_d;
   logic [WD_W-1:0]  width_q, width_d;
   logic [NCH-1:0]   trig_q, trig_d;
   logic [SMP_W-1:0] ring_q [NCH][DEPTH];
   logic [SUM_W-1:0] sum_q [NCH];
   logic [PTR_W-1:0] ptr_q [NCH];
   logic [SMP_W-1:0] dist_q [NCH];
   logic             valid_q, rto_q;
   logic [2:0]       rch_q;
   logic [SMP_W-1:0] ravg_q, bar_q, bar_d;

   logic             slot_end_s, rise_s, fall_s, commit_s, commit_to_s;
   logic [31:0]      shifted_s;
   logic [SMP_W-1:0] meas_smp_s, smp_s, avg_s, sel_avg_s;
   logic [SUM_W-1:0] new_sum_s;

   always_comb begin
      slot_end_s = (slot_q == SLOT_LAST);
      slot_d     = slot_end_s ? '0 : slot_q + 1'b1;
      if (slot_end_s) begin
         ch_d = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
      end else begin
         ch_d = ch_q;
      end
      rise_s = sync2_q[ch_q] & ~prev_q[ch_q];
      fall_s = ~sync2_q[ch_q] & prev_q[ch_q];
   end

   // Per-slot measurement sequencer; slot end always forces a commit if none happened yet.
   always_comb begin
      state_d     = state_q;
      width_d     = width_q;
      commit_s    = 1'b0;
      commit_to_s = 1'b0;
      case (state_q)
         S_TRIG: begin
            if (slot_q == TRIG_LAST) state_d = S_WAIT;
            else                     state_d = S_TRIG;
         end
         S_WAIT: begin
            if (slot_end_s) begin
               commit_s    = 1'b1;
               commit_to_s = 1'b1;
               state_d     = S_TRIG;
            end else if (rise_s) begin
               width_d = WD_W'(1);
               state_d = S_MEAS;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_MEAS: begin
            if (slot_end_s) begin
               commit_s    = 1'b1;
               commit_to_s = 1'b1;
               state_d     = S_TRIG;
            end else if (fall_s) begin
               commit_s = 1'b1;
               state_d  = S_HOLD;
            end else if (width_q >= WD_LAST) begin
               commit_s    = 1'b1;
               commit_to_s = 1'b1;
               width_d     = WD_LIMIT;
               state_d     = S_HOLD;
            end else begin
               width_d = width_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (slot_end_s) state_d = S_TRIG;
            else            state_d = S_HOLD;
         end
         default: state_d = S_TRIG;
      endcase
      trig_d = (state_q == S_TRIG) ? (NCH'(1) << ch_q) : '0;
   end

   always_comb begin
      shifted_s  = 32'(width_q) >> SCALE_SH;
      meas_smp_s = (shifted_s > 32'(SAT)) ? SAT : shifted_s[SMP_W-1:0];
      smp_s      = commit_to_s ? SAT : meas_smp_s;
      new_sum_s  = sum_q[ch_q] - SUM_W'(ring_q[ch_q][ptr_q[ch_q]]) + SUM_W'(smp_s);
      avg_s      = SMP_W'(new_sum_s >> AVG_LOG2);
   end

   // Bar shows the highest set bit of the selected channel's average.
   always_comb begin
      sel_avg_s = '0;
      for (int n = 0; n < NCH; n++) begin
         sel_avg_s = (led_sel == 3'(n)) ? dist_q[n] : sel_avg_s;
      end
      bar_d = '0;
      for (int b = 0; b < SMP_W; b++) begin
         bar_d = sel_avg_s[b] ? (SMP_W'(1) << b) : bar_d;
      end
      dist_flat = '0;
      for (int n = 0; n < NCH; n++) begin
         dist_flat[n*SMP_W +: SMP_W] = dist_q[n];
      end
   end

   always_ff @(posedge osc_clk) begin
      if (stdby_in) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         slot_q  <= '0;
         ch_q    <= '0;
         state_q <= S_TRIG;
         width_q <= '0;
         trig_q  <= '0;
         valid_q <= 1'b0;
         rto_q   <= 1'b0;
         rch_q   <= 3'd0;
         ravg_q  <= '0;
         bar_q   <= '0;
         for (int n = 0; n < NCH; n++) begin
            sum_q[n]  <= '0;
            ptr_q[n]  <= '0;
            dist_q[n] <= '0;
            for (int d = 0; d < DEPTH; d++) begin
               ring_q[n][d] <= '0;
            end
         end
      end else begin
         sync1_q <= echo;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         slot_q  <= slot_d;
         ch_q    <= ch_d;
         state_q <= state_d;
         width_q <= width_d;
         trig_q  <= trig_d;
         valid_q <= commit_s;
         rto_q   <= commit_s & commit_to_s;
         bar_q   <= bar_d;
         if (commit_s) begin
            rch_q                    <= 3'(ch_q);
            ravg_q                   <= avg_s;
            ring_q[ch_q][ptr_q[ch_q]] <= smp_s;
            sum_q[ch_q]              <= new_sum_s;
            ptr_q[ch_q]              <= (ptr_q[ch_q] == PTR_LAST) ? '0 : ptr_q[ch_q] + 1'b1;
            dist_q[ch_q]             <= avg_s;
         end else begin
            rch_q  <= rch_q;
            ravg_q <= ravg_q;
         end
      end
   end

   assign trig          = trig_q;
   assign range_valid   = valid_q;
   assign range_ch      = rch_q;
   assign range_avg     = ravg_q;
   assign range_timeout = rto_q;
   assign bar           = bar_q;

endmodule
